// File: rtl/threeway_pkg.sv
// Shared types, constants and round functions for the 3-Way block cipher core.
package threeway_pkg;

  localparam int          NROUNDS = 11;
  localparam logic [15:0] START_E = 16'h0b0b;
  localparam logic [15:0] START_D = 16'hb1b1;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  typedef logic [95:0] block_t;

  // Linear mixing layer; word order is a0=[31:0], a1=[63:32], a2=[95:64].
  function automatic block_t theta(input block_t a);
    logic [31:0] a0, a1, a2, b0, b1, b2;
    a0 = a[31:0];
    a1 = a[63:32];
    a2 = a[95:64];
    b0 = a0 ^ (a0 >> 16) ^ (a1 << 16) ^ (a1 >> 16) ^ (a2 << 16) ^
         (a1 >> 24) ^ (a2 << 8) ^ (a2 >> 8) ^ (a0 << 24) ^
         (a2 >> 16) ^ (a0 << 16) ^ (a2 >> 24) ^ (a0 << 8);
    b1 = a1 ^ (a1 >> 16) ^ (a2 << 16) ^ (a2 >> 16) ^ (a0 << 16) ^
         (a2 >> 24) ^ (a0 << 8) ^ (a0 >> 8) ^ (a1 << 24) ^
         (a0 >> 16) ^ (a1 << 16) ^ (a0 >> 24) ^ (a1 << 8);
    b2 = a2 ^ (a2 >> 16) ^ (a0 << 16) ^ (a0 >> 16) ^ (a1 << 16) ^
         (a0 >> 24) ^ (a1 << 8) ^ (a1 >> 8) ^ (a2 << 24) ^
         (a1 >> 16) ^ (a2 << 16) ^ (a1 >> 24) ^ (a2 << 8);
    return {b2, b1, b0};
  endfunction

  function automatic block_t pi1(input block_t a);
    return {a[94:64], a[95], a[63:32], a[9:0], a[31:10]};
  endfunction

  function automatic block_t gamma(input block_t a);
    logic [31:0] a0, a1, a2;
    a0 = a[31:0];
    a1 = a[63:32];
    a2 = a[95:64];
    return {a2 ^ (a0 | ~a1), a1 ^ (a2 | ~a0), a0 ^ (a1 | ~a2)};
  endfunction

  // Full 96-bit reversal: a0<-rev(a2), a1<-rev(a1), a2<-rev(a0).
  function automatic block_t mu(input block_t a);
    block_t r;
    for (int i = 0; i < 96; i++) r[i] = a[95-i];
    return r;
  endfunction

  function automatic logic [15:0] rc_next(input logic [15:0] rc);
    logic [16:0] t;
    t = {rc, 1'b0};
    if (t[16]) t = t ^ 17'h11011;
    return t[15:0];
  endfunction

  // Round constant lands in the low half of a2 and the high half of a0.
  function automatic block_t rc_inject(input logic [15:0] rc);
    return {16'h0000, rc, 32'h0000_0000, rc, 16'h0000};
  endfunction

endpackage

// File: rtl/threeway_pi2.sv
// Final permutation of the round: rotate a0 left by 1 and a2 right by 10.
module threeway_pi2
  import threeway_pkg::*;
(
  input  block_t a,
  output block_t y
);

  assign y = {a[73:64], a[95:74], a[63:32], a[30:0], a[31]};

endmodule

// File: rtl/threeway_rho.sv
// Combinational round function rho = pi2(gamma(pi1(theta(t)))).
module threeway_rho
  import threeway_pkg::*;
(
  input  block_t t,
  output block_t y
);

  block_t pre_pi2;

  assign pre_pi2 = gamma(pi1(theta(t)));

  threeway_pi2 u_pi2 (
    .a (pre_pi2),
    .y (y)
  );

endmodule

// File: rtl/threeway_enc_core.sv
// Iterative 3-Way cipher core: one round per clock, 12-cycle fixed latency.
// Define THREEWAY_DECRYPT_EN to add the decrypt input and inverse key schedule.
module threeway_enc_core
  import threeway_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [95:0] iword,
  input  logic [95:0] key,
`ifdef THREEWAY_DECRYPT_EN
  input  logic        decrypt,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [95:0] oword
);

  localparam logic [3:0] LAST_RND = 4'(NROUNDS - 1);

  state_t      st;
  block_t      state_q;
  block_t      key_q;
  logic [15:0] rc_q;
  logic [3:0]  cnt_q;

  block_t      rnd_t;
  block_t      rho_y;
  block_t      fin_t;
  block_t      fin_y;
  block_t      acc_state;
  block_t      acc_key;
  logic [15:0] acc_rc;

  assign rnd_t = state_q ^ key_q ^ rc_inject(rc_q);
  assign fin_t = theta(rnd_t);

  threeway_rho u_rho (
    .t (rnd_t),
    .y (rho_y)
  );

`ifdef THREEWAY_DECRYPT_EN
  logic dec_q;

  // Decryption runs the same rounds on mirrored data with the inverse key.
  assign acc_state = decrypt ? mu(iword) : iword;
  assign acc_key   = decrypt ? mu(theta(key)) : key;
  assign acc_rc    = decrypt ? START_D : START_E;
  assign fin_y     = dec_q ? mu(fin_t) : fin_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dec_q <= 1'b0;
    else if (st == IDLE && in_valid && in_ready)
      dec_q <= decrypt;
  end
`else
  assign acc_state = iword;
  assign acc_key   = key;
  assign acc_rc    = START_E;
  assign fin_y     = fin_t;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      oword     <= '0;
      state_q   <= '0;
      key_q     <= '0;
      rc_q      <= '0;
      cnt_q     <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid && in_ready) begin
            st       <= ROUND;
            in_ready <= 1'b0;
            state_q  <= acc_state;
            key_q    <= acc_key;
            rc_q     <= acc_rc;
            cnt_q    <= '0;
          end
        end
        ROUND: begin
          state_q <= rho_y;
          rc_q    <= rc_next(rc_q);
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == LAST_RND) st <= FINAL;
        end
        FINAL: begin
          oword     <= fin_y;
          out_valid <= 1'b1;
          st        <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_threeway_enc_core.sv
// Scoreboard bench for threeway_enc_core against a word-level 3-Way reference model.
module tb_threeway_enc_core;

  typedef logic [2:0][31:0] w3_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [95:0] iword = '0;
  logic [95:0] key = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [95:0] oword;
`ifdef THREEWAY_DECRYPT_EN
  logic        decrypt = 1'b0;
`endif

  int          n_chk = 0;
  int          n_err = 0;
  logic [95:0] sb_q[$];

  threeway_enc_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .iword     (iword),
    .key       (key),
`ifdef THREEWAY_DECRYPT_EN
    .decrypt   (decrypt),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .oword     (oword)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic w3_t m_theta(input w3_t a);
    w3_t b;
    b[0] = a[0] ^ (a[0] >> 16) ^ (a[1] << 16) ^ (a[1] >> 16) ^ (a[2] << 16) ^
           (a[1] >> 24) ^ (a[2] << 8) ^ (a[2] >> 8) ^ (a[0] << 24) ^
           (a[2] >> 16) ^ (a[0] << 16) ^ (a[2] >> 24) ^ (a[0] << 8);
    b[1] = a[1] ^ (a[1] >> 16) ^ (a[2] << 16) ^ (a[2] >> 16) ^ (a[0] << 16) ^
           (a[2] >> 24) ^ (a[0] << 8) ^ (a[0] >> 8) ^ (a[1] << 24) ^
           (a[0] >> 16) ^ (a[1] << 16) ^ (a[0] >> 24) ^ (a[1] << 8);
    b[2] = a[2] ^ (a[2] >> 16) ^ (a[0] << 16) ^ (a[0] >> 16) ^ (a[1] << 16) ^
           (a[0] >> 24) ^ (a[1] << 8) ^ (a[1] >> 8) ^ (a[2] << 24) ^
           (a[1] >> 16) ^ (a[2] << 16) ^ (a[1] >> 24) ^ (a[2] << 8);
    return b;
  endfunction

  function automatic w3_t m_rho(input w3_t a);
    w3_t b;
    a = m_theta(a);
    a[0] = (a[0] >> 10) ^ (a[0] << 22);
    a[2] = (a[2] << 1) ^ (a[2] >> 31);
    b[0] = a[0] ^ (a[1] | ~a[2]);
    b[1] = a[1] ^ (a[2] | ~a[0]);
    b[2] = a[2] ^ (a[0] | ~a[1]);
    b[2] = (b[2] >> 10) ^ (b[2] << 22);
    b[0] = (b[0] << 1) ^ (b[0] >> 31);
    return b;
  endfunction

  function automatic w3_t m_encrypt(input w3_t a, input w3_t k);
    logic [31:0] rc[12];
    logic [31:0] s;
    s = 32'h0000_0b0b;
    for (int i = 0; i < 12; i++) begin
      rc[i] = s;
      s = s << 1;
      if ((s & 32'h0001_0000) != 0) s = s ^ 32'h0001_1011;
    end
    for (int i = 0; i < 11; i++) begin
      a[0] = a[0] ^ k[0] ^ (rc[i] << 16);
      a[1] = a[1] ^ k[1];
      a[2] = a[2] ^ k[2] ^ rc[i];
      a = m_rho(a);
    end
    a[0] = a[0] ^ k[0] ^ (rc[11] << 16);
    a[1] = a[1] ^ k[1];
    a[2] = a[2] ^ k[2] ^ rc[11];
    return m_theta(a);
  endfunction

  // Drive one block, push its expected result, and wait for out_valid.
  task automatic send(input logic [95:0] iw, input logic [95:0] k,
                      input logic [95:0] exp, input bit perturb);
    int lat;
    @(negedge clk);
    iword    = iw;
    key      = k;
    in_valid = 1'b1;
    chk("in_ready_idle", 96'(in_ready), 96'(1));
    sb_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (perturb && lat >= 1 && lat <= 6) begin
        iword    = {$urandom, $urandom, $urandom};
        key      = {$urandom, $urandom, $urandom};
        in_valid = lat[0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 96'(lat), 96'(12));
  endtask

  // Compare the finished block, optionally stall the consumer, then handshake.
  task automatic collect(input int hold);
    logic [95:0] exp;
    logic [95:0] snap;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 96'(1), 96'(0));
      return;
    end
    exp = sb_q.pop_front();
    chk("out_valid", 96'(out_valid), 96'(1));
    chk("oword", oword, exp);
    snap = oword;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 96'(out_valid), 96'(1));
      chk("hold_oword", oword, snap);
      chk("hold_in_ready", 96'(in_ready), 96'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", 96'(out_valid), 96'(0));
    chk("post_hs_in_ready", 96'(in_ready), 96'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [95:0] pt;
    logic [95:0] kk;
    bit          seen;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_oword", oword, 96'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 96'(in_ready), 96'(1));
    chk("rst_out_valid_rel", 96'(out_valid), 96'(0));

    pt = 96'h0000_0001_0000_0001_0000_0001;
    kk = '0;
    send(pt, kk, m_encrypt(pt, kk), 1'b0);
    collect(0);

    for (int v = 0; v < 100; v++) begin
      case (v)
        0:       begin pt = '0;  kk = '0;  end
        1:       begin pt = '1;  kk = '1;  end
        2:       begin pt = '1;  kk = '0;  end
        default: begin
          pt = {$urandom, $urandom, $urandom};
          kk = {$urandom, $urandom, $urandom};
        end
      endcase
      send(pt, kk, m_encrypt(pt, kk), 1'b0);
      collect(0);
    end

    pt = {$urandom, $urandom, $urandom};
    kk = {$urandom, $urandom, $urandom};
    out_ready = 1'b0;
    send(pt, kk, m_encrypt(pt, kk), 1'b0);
    collect(20);

    pt = 96'h0123_4567_89ab_cdef_fedc_ba98;
    kk = 96'h7654_3210_0f1e_2d3c_4b5a_6978;
    send(pt, kk, m_encrypt(pt, kk), 1'b1);
    collect(0);

    // Abort a block mid-round with reset; nothing may come out afterwards.
    @(negedge clk);
    iword    = {$urandom, $urandom, $urandom};
    key      = {$urandom, $urandom, $urandom};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 96'(out_valid), 96'(0));
    chk("mid_rst_oword", oword, 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    chk("mid_rst_quiet", 96'(seen), 96'(0));

    pt = {$urandom, $urandom, $urandom};
    kk = {$urandom, $urandom, $urandom};
    send(pt, kk, m_encrypt(pt, kk), 1'b0);
    collect(0);

`ifdef THREEWAY_DECRYPT_EN
    for (int v = 0; v < 4; v++) begin
      pt = {$urandom, $urandom, $urandom};
      kk = {$urandom, $urandom, $urandom};
      decrypt = 1'b0;
      send(m_encrypt(pt, kk), kk, pt, 1'b0);
      sb_q.pop_back();
      sb_q.push_back(m_encrypt(pt, kk));
      collect(0);
      decrypt = 1'b1;
      send(m_encrypt(pt, kk), kk, pt, 1'b0);
      collect(0);
      decrypt = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
